// File: rtl/div_pkg.sv
// Shared constants, state encoding and result helpers for the divide issue stage.
package div_pkg;

  localparam int XLEN        = 64;
  localparam int OP_UNSIGNED = 0;
  localparam int OP_REM      = 1;
  localparam int OP_WORD     = 2;

  localparam logic [XLEN-1:0] MIN_INT64 = 64'h8000_0000_0000_0000;
  localparam logic [31:0]     MIN_INT32 = 32'h8000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } div_state_e;

  typedef struct packed {
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic            sgn;
  } div_operands_t;

  function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] v);
    return {{32{v[31]}}, v[31:0]};
  endfunction

  // W forms always sign-extend bit 31, unsigned ones included.
  function automatic logic [XLEN-1:0] sel_result(input logic [2:0]      op,
                                                 input logic [XLEN-1:0] quo,
                                                 input logic [XLEN-1:0] rem);
    logic [XLEN-1:0] val;
    val = op[OP_REM] ? rem : quo;
    return op[OP_WORD] ? sext_w(val) : val;
  endfunction

endpackage

// File: rtl/div_issue_ctrl_if.sv
// Request, result and divider-core signals of the divide issue stage.
interface div_issue_ctrl_if import div_pkg::*; #(
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [TAG_W-1:0] in_tag;
  logic [XLEN-1:0]  in_src1;
  logic [XLEN-1:0]  in_src2;

  logic             out_valid;
  logic             out_ready;
  logic [TAG_W-1:0] out_tag;
  logic [XLEN-1:0]  out_result;

  logic             core_en;
  logic             core_flush;
  logic             core_opcode;
  logic [XLEN-1:0]  core_dividend;
  logic [XLEN-1:0]  core_divisor;
  logic             core_valid;
  logic [XLEN-1:0]  core_quotient;
  logic [XLEN-1:0]  core_remainder;

  modport slave (
    input  in_valid, in_op, in_tag, in_src1, in_src2, out_ready,
           core_valid, core_quotient, core_remainder,
    output in_ready, out_valid, out_tag, out_result,
           core_en, core_flush, core_opcode, core_dividend, core_divisor
  );

  modport master (
    output in_valid, in_op, in_tag, in_src1, in_src2, out_ready,
           core_valid, core_quotient, core_remainder,
    input  in_ready, out_valid, out_tag, out_result,
           core_en, core_flush, core_opcode, core_dividend, core_divisor
  );
endinterface

// File: rtl/div_pre_decode.sv
// Operand extension plus divide-by-zero / signed-overflow detection and bypass result.
module div_pre_decode import div_pkg::*; (
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_src1,
  input  logic [XLEN-1:0] i_src2,
  output div_operands_t   o_opnd,
  output logic            o_special,
  output logic [XLEN-1:0] o_bypass
);
  logic            w_word;
  logic            w_sgn;
  logic            w_div0;
  logic            w_ovf;
  logic [XLEN-1:0] w_dvd;
  logic [XLEN-1:0] w_dvs;
  logic [XLEN-1:0] w_quo;
  logic [XLEN-1:0] w_rem;

  always_comb begin
    w_word = i_op[OP_WORD];
    w_sgn  = ~i_op[OP_UNSIGNED];
    w_dvd  = i_src1;
    w_dvs  = i_src2;
    if (w_word) begin
      w_dvd = w_sgn ? sext_w(i_src1) : {32'b0, i_src1[31:0]};
      w_dvs = w_sgn ? sext_w(i_src2) : {32'b0, i_src2[31:0]};
    end

    // Checks use 32-bit semantics for W ops so upper-half garbage never matters.
    w_div0 = w_word ? (w_dvs[31:0] == 32'b0) : (w_dvs == '0);
    w_ovf  = w_sgn & (w_word ? (w_dvd[31:0] == MIN_INT32 && w_dvs[31:0] == 32'hFFFF_FFFF)
                             : (w_dvd == MIN_INT64 && w_dvs == '1));

    w_quo = '0;
    w_rem = '0;
    if (w_div0) begin
      w_quo = '1;
      w_rem = w_dvd;
    end else if (w_ovf) begin
      w_quo = w_dvd;
      w_rem = '0;
    end

    o_opnd.dividend = w_dvd;
    o_opnd.divisor  = w_dvs;
    o_opnd.sgn      = w_sgn;
    o_special       = w_div0 | w_ovf;
    o_bypass        = sel_result(i_op, w_quo, w_rem);
  end
endmodule

// File: rtl/div_issue_ctrl.sv
// Issue/sequencing stage in front of the iterative 64-bit divider core.
module div_issue_ctrl import div_pkg::*; #(
  parameter int TAG_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  div_issue_ctrl_if.slave  io
);
  div_state_e       r_state;
  div_state_e       w_nxt;
  logic [XLEN-1:0]  r_dividend;
  logic [XLEN-1:0]  r_divisor;
  logic             r_opcode;
  logic [2:0]       r_op;
  logic [TAG_W-1:0] r_tag;
  logic             r_core_en;
  logic [XLEN-1:0]  r_out_result;
  logic [TAG_W-1:0] r_out_tag;

  div_operands_t    w_opnd;
  logic             w_special;
  logic [XLEN-1:0]  w_bypass;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_core_done;

  div_pre_decode u_pre (
    .i_op      (io.in_op),
    .i_src1    (io.in_src1),
    .i_src2    (io.in_src2),
    .o_opnd    (w_opnd),
    .o_special (w_special),
    .o_bypass  (w_bypass)
  );

  assign w_in_ready  = (r_state == S_IDLE) & ~flush;
  assign w_accept    = io.in_valid & w_in_ready;
  assign w_core_done = (r_state == S_BUSY) & io.core_valid & ~flush;

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept)     w_nxt = w_special ? S_DONE : S_BUSY;
      S_BUSY: if (io.core_valid) w_nxt = S_DONE;
      S_DONE: if (io.out_ready)  w_nxt = S_IDLE;
      default:                   w_nxt = S_IDLE;
    endcase
    // Flush wins over core completion and downstream accept.
    if (flush) w_nxt = S_IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_dividend   <= '0;
      r_divisor    <= '0;
      r_opcode     <= 1'b0;
      r_op         <= '0;
      r_tag        <= '0;
      r_core_en    <= 1'b0;
      r_out_result <= '0;
      r_out_tag    <= '0;
    end else begin
      r_core_en <= 1'b0;
      if (w_accept) begin
        r_op  <= io.in_op;
        r_tag <= io.in_tag;
        if (w_special) begin
          r_out_result <= w_bypass;
          r_out_tag    <= io.in_tag;
        end else begin
          r_dividend <= w_opnd.dividend;
          r_divisor  <= w_opnd.divisor;
          r_opcode   <= w_opnd.sgn;
          r_core_en  <= 1'b1;
        end
      end
      if (w_core_done) begin
        r_out_result <= sel_result(r_op, io.core_quotient, io.core_remainder);
        r_out_tag    <= r_tag;
      end
    end
  end

  assign io.in_ready      = w_in_ready;
  assign io.out_valid     = (r_state == S_DONE);
  assign io.out_tag       = r_out_tag;
  assign io.out_result    = r_out_result;
  assign io.core_en       = r_core_en;
  assign io.core_flush    = flush;
  assign io.core_opcode   = r_opcode;
  assign io.core_dividend = r_dividend;
  assign io.core_divisor  = r_divisor;
endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
- Issue/sequencing stage in front of the 64-bit iterative integer divider core.
- Accepts RV64M divide ops (DIV/DIVU/REM/REMU and the W forms) over a valid/ready handshake, and resolves divide-by-zero and signed overflow without using the core.
- For all other ops it extends the operands, launches the core and holds the operands stable while the core runs.
- It then selects the quotient or remainder, sign-extends W results, and holds the result until downstream accepts it.

Parameters:
TAG_W, 5, width of the opaque tag carried from the request to the result.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
flush  in  1  pipeline flush; aborts any in-flight op
in_valid  in  1  request valid
in_ready  out  1  block can accept a request
in_op  in  3  [0]=unsigned, [1]=remainder, [2]=word (32-bit)
in_tag  in  TAG_W  request tag
in_src1  in  64  dividend
in_src2  in  64  divisor
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_tag  out  TAG_W  tag of the result
out_result  out  64  final result
core_en  out  1  one-cycle launch pulse to the divider core
core_flush  out  1  abort to the core
core_opcode  out  1  1=signed division
core_dividend  out  64  extended dividend, held stable while BUSY
core_divisor  out  64  extended divisor, held stable while BUSY
core_valid  in  1  core result valid pulse
core_quotient  in  64  core quotient
core_remainder  in  64  core remainder

Behaviour:
- Clock is `clock`. Reset is `reset`: synchronous, active-high. Both are fixed.
- States: IDLE, BUSY, DONE. Reset puts the block in IDLE with out_valid=0, out_result=0, out_tag=0, core_en=0 and operand registers=0.
- in_ready = (state==IDLE) & ~flush. Accept = in_valid & in_ready.
- Operand extension:
  - Word op: use src[31:0], sign-extended when signed, zero-extended when unsigned.
  - Otherwise use the full 64 bits.
  - core_opcode = ~in_op[0].
- Special cases are evaluated on the extended operands, using 32-bit semantics for W ops:
  - Divisor==0: quotient = all ones; remainder = dividend.
  - Signed, dividend = most-negative value, divisor = -1: quotient = dividend; remainder = 0.
- On accept with a special case:
  - Next state is DONE; out_result is registered directly, giving out_valid one cycle after accept.
  - core_en is never asserted.
- On accept with a normal case:
  - Latch the extended operands, op and tag; next state is BUSY.
  - core_en = 1 for exactly the first BUSY cycle, then 0.
  - core_dividend, core_divisor and core_opcode stay constant for the whole of BUSY.
- BUSY to DONE on core_valid. In that cycle out_result latches:
  - the remainder when op[1]=1, else the quotient;
  - for a W op, {32{r[31]}, r[31:0]} of that value (also applies to DIVUW/REMUW).
- DONE: out_valid=1; out_result and out_tag are stable until out_valid & out_ready, then IDLE. in_ready stays 0 in DONE, so there is no back-to-back overlap.
- Special-case W results are sign-extended the same way.
- core_valid is ignored in IDLE and DONE.
- flush:
  - core_flush = flush, passed through combinationally.
  - Flush forces the next state to IDLE from any state and clears out_valid next cycle.
  - A request presented in the same cycle as flush is not accepted.
  - Flush has priority over core_valid and over out_ready.
- reset has priority over everything; asserting it mid-BUSY returns the block to IDLE with reset values next cycle.
- Latency:
  - Special case: 1 cycle accept-to-out_valid.
  - Normal case: (core latency from core_en) + 1 cycle.

Decomposition:
- Shared package div_pkg:
  - op-bit position constants (OP_UNSIGNED=0, OP_REM=1, OP_WORD=2);
  - state encoding;
  - XLEN=64 and the MIN_INT64/MIN_INT32 constants.
- One combinational sub-module, div_pre_decode: operand extension plus special-case detection and the bypass result.
- The FSM, operand registers and result register stay in the top module.
- The divider core is connected externally by the integrating wrapper.

Test Plan:
1. DIV, src1=0xFFFF_FFFF_FFFF_FFF9 (-7), src2=2:
   - core_en pulses once;
   - result 0xFFFF_FFFF_FFFF_FFFD, out_valid 1 cycle after core_valid;
   - REM of the same operands gives 0xFFFF_FFFF_FFFF_FFFF.
2. DIVU, src1=0x1234, src2=0:
   - out_valid 1 cycle after accept, result 0xFFFF_FFFF_FFFF_FFFF, core_en never high;
   - REMU of the same operands gives 0x1234.
3. DIV, src1=0x8000_0000_0000_0000, src2=0xFFFF_FFFF_FFFF_FFFF:
   - bypass result 0x8000_0000_0000_0000;
   - REM of the same operands gives 0.
4. W ops:
   - DIVW, src1=0xDEAD_BEEF_FFFF_FFF0, src2=0x1_0000_0003 → core_dividend 0xFFFF_FFFF_FFFF_FFF0, result 0xFFFF_FFFF_FFFF_FFFB;
   - DIVUW, src1=0x8000_0000, src2=1 → 0xFFFF_FFFF_8000_0000.
5. Flush 10 cycles into BUSY:
   - core_flush high in the same cycle; in_ready=1 next cycle; no out_valid;
   - a stray core_valid is ignored;
   - a following DIV 100/7 returns 14.
6. Backpressure and reset:
   - out_ready=0 for 5 cycles → out_valid, out_result and out_tag stable, in_ready=0;
   - reset asserted mid-BUSY → out_valid=0, core_en=0, in_ready=1 next cycle.
